polar_pkt_sched: RTL
====================

// Module: polar_pkt_sched
// PURPOSE
//  Packet-level sequencer for the SC polar decoder. Walks the LLR memory, reads the packet count and each
//  packet's N/K header, and streams N/16 LLR lines into the decode core. It then waits for the core,
//  writes the K decoded bits to DEC memory and pulses proc_done after the last packet.
//  Sits between the testbench memories and the decode datapath; owns all memory addressing.
// PARAMETERS
//  PKT_LINES  33   LLR-memory lines per packet (1 header + 32 LLR lines)
//  LLR_W      12   bits per LLR; 16 LLRs per 192-bit line
//  MAX_K      140  width of a decoded word
// PORTS
//  clk         in   1    rising-edge clock
//  rst         in   1    asynchronous, active-high reset
//  module_en   in   1    level; start when sampled high in IDLE
//  raddr       out  11   LLR memory read address (registered)
//  rdata       in   192  LLR memory data; valid the cycle after raddr is presented
//  core_start  out  1    1-cycle pulse: new packet; core_n_sel/core_k valid this cycle
//  core_n_sel  out  2    0:N=128 1:N=256 2:N=512
//  core_k      out  8    K of current packet
//  llr_valid   out  1    LLR beat strobe; core must accept every beat (no backpressure)
//  llr_idx     out  5    beat index 0..N/16-1
//  llr_line    out  192  copy of rdata for this beat
//  core_done   in   1    1-cycle pulse; core_bits valid same cycle
//  core_bits   in   140  decoded bits, bit i = u_hat info bit i
//  dec_wen     out  1    DEC memory write strobe
//  waddr       out  6    DEC memory address = packet index
//  wdata       out  140  decoded word, bits >= K forced 0
//  proc_done   out  1    1-cycle pulse after the last write
// BEHAVIOUR
//  Reset: state=IDLE; raddr=0, waddr=0, wdata=0; all strobes (core_start, llr_valid, dec_wen,
//   proc_done) 0; core_n_sel=0, core_k=0, llr_idx=0, llr_line=0; packet counters 0.
//  Memory map: addr 0 = packet count rdata[6:0]. Packet p header at 1+33p: N=rdata[9:0], K=rdata[17:10].
//   LLR line j of packet p is at 2+33p+j.
//  FSM: IDLE -> RD_CNT -> RD_HDR -> LD_LLR -> WAIT_DEC -> WR_OUT -> (RD_HDR | DONE) -> IDLE.
//   IDLE: on module_en, raddr<=0 -> RD_CNT.
//   RD_CNT: latch count. count==0 -> DONE. Otherwise raddr<=1 -> RD_HDR.
//   RD_HDR: latch N, K; pulse core_start; raddr<=header+1 -> LD_LLR.
//   LD_LLR: issues N/16 consecutive addresses, one per cycle. Beat j appears one cycle after its
//    address, with llr_valid=1 and llr_idx=j. After the last beat -> WAIT_DEC.
//   WAIT_DEC: hold until core_done. Latch core_bits masked to K bits -> WR_OUT.
//   WR_OUT: dec_wen=1 for exactly 1 cycle, waddr=p, wdata=masked word.
//    p+1==count -> DONE. Otherwise p++, raddr<=1+33(p+1) -> RD_HDR.
//   DONE: proc_done=1 for 1 cycle -> IDLE.
//  Header-to-first-beat latency is 2 cycles. A packet occupies N/16+4 cycles plus decode time.
//  Address arithmetic is 11-bit unsigned; max address 1+33*44+32 < 2048, so no wrap handling.
//  module_en is ignored outside IDLE. A level held high after DONE restarts from IDLE.
//  core_done outside WAIT_DEC is ignored.
//  rst asserted mid-operation aborts immediately to reset values. No partial write completes.
//  Unknown N encoding without the check option is treated as N=512.
// CONFIGURATION
//  POLAR_SCHED_HDR_CHECK_EN defined:
//   - Adds output hdr_err (1 bit, sticky until next start, reset 0).
//   - Header is invalid if N is not 128/256/512, or K==0, or K>N, or K>140.
//   - On an invalid header: skip LD_LLR and WAIT_DEC, no core_start, write wdata=0 to waddr=p,
//     set hdr_err, continue with the next packet.
//  Undefined: headers are trusted, there is no hdr_err port, and the rules above apply as written.
// STRUCTURE
//  Shared package polar_pkg: state encoding, PKT_LINES, N_SEL_* codes, the N->beats function
//   (8/16/32), and the K-mask width MAX_K.
//  One sub-module: polar_kmask (combinational K -> 140-bit mask), also reused by the decode core.
//  Everything else stays flat in this module.
// TESTING
//  1. count=1, N=128, K=64: 8 beats from addr 2..9; core_done with all-ones bits ->
//     wdata has low 64 bits=1, rest 0; waddr=0; proc_done 1 cycle later.
//  2. count=3 with N=512/256/128: raddr sequence 1,2..33 then 34,35..50 then 67,68..75;
//     waddr 0,1,2; exactly one proc_done.
//  3. count=0: no core_start, no dec_wen; proc_done pulses 2 cycles after IDLE exit.
//  4. Delay core_done by 0 and by 500 cycles, toggle module_en mid-packet, and pulse a spurious
//     core_done during LD_LLR -> outputs unchanged apart from timing.
//  5. Assert rst during LD_LLR beat 5 -> next cycle all outputs at reset values; a restart decodes
//     correctly.
//  6. (HDR_CHECK_EN) packet 1 has N=300 -> waddr=1 gets 0, hdr_err=1, packet 2 still decoded.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared definitions for the SC polar decoder: scheduler states, memory layout,
// N/K header decoding and the N -> LLR-beat mapping.
package polar_pkg;

    localparam int unsigned PKT_LINES     = 33;
    localparam int unsigned LLR_W         = 12;
    localparam int unsigned LLRS_PER_LINE = 16;
    localparam int unsigned LINE_W        = LLR_W * LLRS_PER_LINE;
    localparam int unsigned MAX_K         = 140;
    localparam int unsigned RADDR_W       = 11;
    localparam int unsigned WADDR_W       = 6;
    localparam int unsigned N_W           = 10;
    localparam int unsigned K_W           = 8;
    localparam int unsigned CNT_W         = 7;
    localparam int unsigned BEAT_W        = 5;
    localparam int unsigned NSEL_W        = 2;

    localparam logic [NSEL_W-1:0] N_SEL_128 = NSEL_W'(0);
    localparam logic [NSEL_W-1:0] N_SEL_256 = NSEL_W'(1);
    localparam logic [NSEL_W-1:0] N_SEL_512 = NSEL_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_RD_HDR,
        ST_LD_LLR,
        ST_WAIT_DEC,
        ST_WR_OUT,
        ST_DONE
    } sched_state_t;

    // Packet header as stored in the low bits of its LLR-memory line.
    typedef struct packed {
        logic [K_W-1:0] k;
        logic [N_W-1:0] n;
    } pkt_hdr_t;

    // Any unrecognised N falls back to the largest code.
    function automatic logic [NSEL_W-1:0] n_sel_of(input logic [N_W-1:0] n);
        case (n)
            N_W'(128): n_sel_of = N_SEL_128;
            N_W'(256): n_sel_of = N_SEL_256;
            default:   n_sel_of = N_SEL_512;
        endcase
    endfunction

    function automatic logic [BEAT_W:0] n_beats(input logic [NSEL_W-1:0] sel);
        case (sel)
            N_SEL_128: n_beats = (BEAT_W+1)'(8);
            N_SEL_256: n_beats = (BEAT_W+1)'(16);
            default:   n_beats = (BEAT_W+1)'(32);
        endcase
    endfunction

    function automatic logic n_is_legal(input logic [N_W-1:0] n);
        n_is_legal = (n == N_W'(128)) || (n == N_W'(256)) || (n == N_W'(512));
    endfunction

endpackage

// File: rtl/polar_pkt_sched_if.sv
// Scheduler bus: LLR memory read port, decode-core handshake and DEC memory write port.
// hdr_err exists only when POLAR_SCHED_HDR_CHECK_EN is defined.
interface polar_pkt_sched_if;
    import polar_pkg::*;

    logic                  module_en;
    logic [RADDR_W-1:0]    raddr;
    logic [LINE_W-1:0]     rdata;
    logic                  core_start;
    logic [NSEL_W-1:0]     core_n_sel;
    logic [K_W-1:0]        core_k;
    logic                  llr_valid;
    logic [BEAT_W-1:0]     llr_idx;
    logic [LINE_W-1:0]     llr_line;
    logic                  core_done;
    logic [MAX_K-1:0]      core_bits;
    logic                  dec_wen;
    logic [WADDR_W-1:0]    waddr;
    logic [MAX_K-1:0]      wdata;
    logic                  proc_done;
`ifdef POLAR_SCHED_HDR_CHECK_EN
    logic                  hdr_err;
`endif

    modport master (
        input  module_en, rdata, core_done, core_bits,
`ifdef POLAR_SCHED_HDR_CHECK_EN
        output hdr_err,
`endif
        output raddr, core_start, core_n_sel, core_k, llr_valid, llr_idx, llr_line,
               dec_wen, waddr, wdata, proc_done
    );

    modport slave (
        output module_en, rdata, core_done, core_bits,
`ifdef POLAR_SCHED_HDR_CHECK_EN
        input  hdr_err,
`endif
        input  raddr, core_start, core_n_sel, core_k, llr_valid, llr_idx, llr_line,
               dec_wen, waddr, wdata, proc_done
    );

endinterface

// File: rtl/polar_kmask.sv
// Combinational K -> MAX_K-bit mask with the low K bits set; K >= MAX_K gives all ones.
module polar_kmask
    import polar_pkg::*;
(
    input  logic [K_W-1:0]   k,
    output logic [MAX_K-1:0] mask_c
);

    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < MAX_K; i++) begin
            mask_c[i] = (i < 32'(k));
        end
    end

endmodule

// File: rtl/polar_pkt_sched.sv
// Packet sequencer for the SC polar decoder: reads packet headers and LLR lines, feeds the
// decode core and writes masked decoded words. Define POLAR_SCHED_HDR_CHECK_EN for header validation.
module polar_pkt_sched
    import polar_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    polar_pkt_sched_if.master bus
);

    sched_state_t       state;
    logic [CNT_W-1:0]   pkt_cnt;
    logic [CNT_W-1:0]   pkt_idx;
    logic [RADDR_W-1:0] hdr_addr;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [BEAT_W:0]    beats;
    logic [MAX_K-1:0]   kmask_c;
    pkt_hdr_t           hdr_c;
    logic               hdr_ok_c;

    assign hdr_c = pkt_hdr_t'(bus.rdata[$bits(pkt_hdr_t)-1:0]);

`ifdef POLAR_SCHED_HDR_CHECK_EN
    assign hdr_ok_c = n_is_legal(hdr_c.n)
                   && (hdr_c.k != '0)
                   && ({2'b00, hdr_c.k} <= hdr_c.n)
                   && (hdr_c.k <= K_W'(MAX_K));
`else
    assign hdr_ok_c = 1'b1;
`endif

    // Mask follows the latched K of the packet currently in flight.
    polar_kmask u_kmask (
        .k      (bus.core_k),
        .mask_c (kmask_c)
    );

    // Strobes are asserted on the edge entering the state they belong to, so dec_wen is high
    // during WR_OUT and proc_done during DONE; core_start accompanies the latched N/K.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            pkt_cnt        <= '0;
            pkt_idx        <= '0;
            hdr_addr       <= '0;
            beat_cnt       <= '0;
            beats          <= '0;
            bus.raddr      <= '0;
            bus.core_start <= 1'b0;
            bus.core_n_sel <= '0;
            bus.core_k     <= '0;
            bus.llr_valid  <= 1'b0;
            bus.llr_idx    <= '0;
            bus.llr_line   <= '0;
            bus.dec_wen    <= 1'b0;
            bus.waddr      <= '0;
            bus.wdata      <= '0;
            bus.proc_done  <= 1'b0;
`ifdef POLAR_SCHED_HDR_CHECK_EN
            bus.hdr_err    <= 1'b0;
`endif
        end else begin
            bus.core_start <= 1'b0;
            bus.llr_valid  <= 1'b0;
            bus.dec_wen    <= 1'b0;
            bus.proc_done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.module_en) begin
                        bus.raddr <= '0;
                        pkt_idx   <= '0;
`ifdef POLAR_SCHED_HDR_CHECK_EN
                        bus.hdr_err <= 1'b0;
`endif
                        state     <= ST_RD_CNT;
                    end
                end

                ST_RD_CNT: begin
                    pkt_cnt <= bus.rdata[CNT_W-1:0];
                    if (bus.rdata[CNT_W-1:0] == '0) begin
                        bus.proc_done <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        hdr_addr  <= RADDR_W'(1);
                        bus.raddr <= RADDR_W'(1);
                        state     <= ST_RD_HDR;
                    end
                end

                ST_RD_HDR: begin
                    bus.core_k     <= hdr_c.k;
                    bus.core_n_sel <= n_sel_of(hdr_c.n);
                    beats          <= n_beats(n_sel_of(hdr_c.n));
                    beat_cnt       <= '0;
                    if (hdr_ok_c) begin
                        bus.core_start <= 1'b1;
                        bus.raddr      <= bus.raddr + RADDR_W'(1);
                        state          <= ST_LD_LLR;
                    end else begin
                        // Rejected header: write a zero word in the packet's slot and move on.
                        bus.wdata   <= '0;
                        bus.waddr   <= pkt_idx[WADDR_W-1:0];
                        bus.dec_wen <= 1'b1;
`ifdef POLAR_SCHED_HDR_CHECK_EN
                        bus.hdr_err <= 1'b1;
`endif
                        state       <= ST_WR_OUT;
                    end
                end

                ST_LD_LLR: begin
                    bus.llr_valid <= 1'b1;
                    bus.llr_idx   <= beat_cnt;
                    bus.llr_line  <= bus.rdata;
                    if ({1'b0, beat_cnt} == beats - (BEAT_W+1)'(1)) begin
                        state <= ST_WAIT_DEC;
                    end else begin
                        beat_cnt  <= beat_cnt + BEAT_W'(1);
                        bus.raddr <= bus.raddr + RADDR_W'(1);
                    end
                end

                ST_WAIT_DEC: begin
                    if (bus.core_done) begin
                        bus.wdata   <= bus.core_bits & kmask_c;
                        bus.waddr   <= pkt_idx[WADDR_W-1:0];
                        bus.dec_wen <= 1'b1;
                        state       <= ST_WR_OUT;
                    end
                end

                ST_WR_OUT: begin
                    if (pkt_idx + CNT_W'(1) == pkt_cnt) begin
                        bus.proc_done <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        pkt_idx   <= pkt_idx + CNT_W'(1);
                        hdr_addr  <= hdr_addr + RADDR_W'(PKT_LINES);
                        bus.raddr <= hdr_addr + RADDR_W'(PKT_LINES);
                        state     <= ST_RD_HDR;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
